// File: rtl/syscall_responder_if.sv
// Bundle of syscall request/stall, data-memory byte read and console byte stream signals.
// master = core/memory/console side, slave = syscall_responder.
interface syscall_responder_if;
    logic        syscall_valid;
    logic [31:0] syscall_funct;
    logic [31:0] syscall_param1;
    logic        syscall_busy;
    logic        syscall_done;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        halted;
    logic [7:0]  exit_code;

    modport master (
        output syscall_valid, syscall_funct, syscall_param1, mem_rdata, tx_ready,
        input  syscall_busy, syscall_done, mem_rd_en, mem_addr, tx_valid, tx_data, halted, exit_code
    );

    modport slave (
        input  syscall_valid, syscall_funct, syscall_param1, mem_rdata, tx_ready,
        output syscall_busy, syscall_done, mem_rd_en, mem_addr, tx_valid, tx_data, halted, exit_code
    );
endinterface

// File: rtl/syscall_responder.sv
// Runs MIPS syscall services (print char/int/string, exit) while stalling decode via busy.
// Latency is service dependent; every tx_ready=0 cycle holds the byte and adds one cycle.
module syscall_responder #(
    parameter int MAX_STR = 256
) (
    input  logic               clock,
    input  logic               reset_n,
    syscall_responder_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_STR + 1);

    typedef enum logic [3:0] {
        IDLE, CHAR, CONV, SIGN, DIGIT, STR_RD, STR_WAIT, STR_EMIT, DONE, HALT
    } state_t;

    state_t           state, nextState;
    logic [7:0]       charByte;
    logic             isNeg;
    logic [31:0]      bin, binNext;
    logic [39:0]      bcd, bcdAdj, bcdNext;
    logic [4:0]       iterCnt;
    logic [3:0]       digitIdx, msdIdx;
    logic [3:0]       digit;
    logic [31:0]      ptr;
    logic [CNT_W-1:0] byteCnt;
    logic [7:0]       curByte;
    logic [7:0]       exitCode;
    logic             txValid;
    logic             txFire;
    logic             accept;

    assign accept = (state == IDLE) && bus.syscall_valid;
    assign txFire = txValid && bus.tx_ready;

    // One double-dabble iteration: add 3 to digits >= 5, then shift bin into bcd.
    always_comb begin
        bcdAdj = bcd;
        for (int i = 0; i < 10; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcdAdj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        bcdNext = {bcdAdj[38:0], bin[31]};
        binNext = {bin[30:0], 1'b0};
        msdIdx  = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (bcdNext[4*i +: 4] != 4'd0) msdIdx = 4'(i);
        end
        digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (digitIdx == 4'(i)) digit = bcd[4*i +: 4];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (bus.syscall_valid) begin
                case (bus.syscall_funct)
                    32'd1:          nextState = CONV;
                    32'd4:          nextState = STR_RD;
                    32'd10, 32'd17: nextState = HALT;
                    32'd11:         nextState = CHAR;
                    default:        nextState = DONE;
                endcase
            end
            CHAR:     if (txFire) nextState = DONE;
            CONV:     if (iterCnt == 5'd31) nextState = isNeg ? SIGN : DIGIT;
            SIGN:     if (txFire) nextState = DIGIT;
            DIGIT:    if (txFire && digitIdx == 4'd0) nextState = DONE;
            STR_RD:   nextState = STR_WAIT;
            STR_WAIT: nextState = (bus.mem_rdata == 8'h00 || byteCnt == CNT_W'(MAX_STR)) ? DONE : STR_EMIT;
            STR_EMIT: if (txFire) nextState = STR_RD;
            DONE:     nextState = IDLE;
            HALT:     nextState = HALT;
            default:  nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.syscall_busy = 1'b1;
        bus.syscall_done = 1'b0;
        bus.mem_rd_en    = 1'b0;
        bus.tx_data      = 8'h00;
        txValid          = 1'b0;
        case (state)
            IDLE:     bus.syscall_busy = bus.syscall_valid;
            CHAR:     begin txValid = 1'b1; bus.tx_data = charByte; end
            SIGN:     begin txValid = 1'b1; bus.tx_data = 8'h2D; end
            DIGIT:    begin txValid = 1'b1; bus.tx_data = 8'h30 + {4'h0, digit}; end
            STR_RD:   bus.mem_rd_en = 1'b1;
            STR_EMIT: begin txValid = 1'b1; bus.tx_data = curByte; end
            DONE:     begin bus.syscall_busy = 1'b0; bus.syscall_done = 1'b1; end
            default:  ;
        endcase
        bus.tx_valid  = txValid;
        bus.halted    = (state == HALT);
        bus.exit_code = exitCode;
        bus.mem_addr  = ptr;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            charByte <= 8'h00;
            isNeg    <= 1'b0;
            bin      <= 32'h0;
            bcd      <= 40'h0;
            iterCnt  <= 5'd0;
            digitIdx <= 4'd0;
            ptr      <= 32'h0;
            byteCnt  <= '0;
            curByte  <= 8'h00;
            exitCode <= 8'h00;
        end else if (accept) begin
            charByte <= bus.syscall_param1[7:0];
            isNeg    <= bus.syscall_param1[31];
            // Two's-complement negate; 0x80000000 stays 2^31, read as unsigned.
            bin      <= bus.syscall_param1[31] ? (~bus.syscall_param1 + 32'd1) : bus.syscall_param1;
            bcd      <= 40'h0;
            iterCnt  <= 5'd0;
            ptr      <= bus.syscall_param1;
            byteCnt  <= '0;
            if (bus.syscall_funct == 32'd10)      exitCode <= 8'h00;
            else if (bus.syscall_funct == 32'd17) exitCode <= bus.syscall_param1[7:0];
        end else begin
            case (state)
                CONV: begin
                    bcd     <= bcdNext;
                    bin     <= binNext;
                    iterCnt <= iterCnt + 5'd1;
                    if (iterCnt == 5'd31) digitIdx <= msdIdx;
                end
                DIGIT:    if (txFire && digitIdx != 4'd0) digitIdx <= digitIdx - 4'd1;
                STR_WAIT: curByte <= bus.mem_rdata;
                STR_EMIT: if (txFire) begin
                    ptr     <= ptr + 32'd1;
                    byteCnt <= byteCnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_syscall_responder.sv
// Directed-vector bench for syscall_responder with byte-memory and console monitors.
module tb_syscall_responder;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    syscall_responder_if bus();

    syscall_responder #(.MAX_STR(256)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad = 0;
    int doneCnt = 0;
    int lat;
    logic [7:0]  mem [0:1023];
    logic [7:0]  txQ [$];
    logic [31:0] rdQ [$];
    logic [7:0]  expQ [$];

    always @(posedge clock) bus.mem_rdata <= mem[bus.mem_addr[9:0]];

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.tx_valid && bus.tx_ready) txQ.push_back(bus.tx_data);
            if (bus.mem_rd_en) rdQ.push_back(bus.mem_addr);
            if (bus.syscall_done) doneCnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expStr(input string s);
        expQ.delete();
        for (int i = 0; i < s.len(); i++) expQ.push_back(s[i]);
    endtask

    task automatic chkBytes(input string tag);
        chk({tag, "_len"}, txQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < txQ.size(); i++) chk(tag, txQ[i], expQ[i]);
    endtask

    task automatic runSyscall(input logic [31:0] f, input logic [31:0] p, output int latency);
        int n;
        bit seen;
        txQ.delete();
        rdQ.delete();
        @(posedge clock); #1;
        bus.syscall_valid = 1'b1;
        bus.syscall_funct = f;
        bus.syscall_param1 = p;
        n = 0;
        seen = 1'b0;
        latency = -1;
        @(negedge clock);
        chk("busy_accept", bus.syscall_busy, 1);
        while (!seen && n < 2000) begin
            @(negedge clock);
            n++;
            if (bus.syscall_done) begin
                seen = 1'b1;
                latency = n;
                chk("busy_in_done", bus.syscall_busy, 0);
            end
        end
        chk("done_seen", seen, 1);
        @(posedge clock); #1;
        bus.syscall_valid = 1'b0;
    endtask

    initial begin
        bus.syscall_valid = 1'b0;
        bus.syscall_funct = 32'h0;
        bus.syscall_param1 = 32'h0;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h100] = 8'h48;
        mem[10'h101] = 8'h69;
        mem[10'h102] = 8'h00;
        for (int i = 0; i < 300; i++) mem[10'h200 + i] = 8'h41 + 8'(i % 26);

        // Reset state
        #12;
        chk("rst_busy", bus.syscall_busy, 0);
        chk("rst_done", bus.syscall_done, 0);
        chk("rst_rd_en", bus.mem_rd_en, 0);
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_exit_code", bus.exit_code, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        bus.syscall_valid = 1'b1;
        #1;
        chk("rst_busy_valid", bus.syscall_busy, 1);
        bus.syscall_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;

        runSyscall(32'd11, 32'h00000141, lat);
        chk("char_lat", lat, 2);
        expStr("A");
        chkBytes("char_bytes");

        runSyscall(32'd5, 32'h0, lat);
        chk("noop_lat", lat, 1);
        chk("noop_bytes", txQ.size(), 0);

        runSyscall(32'd1, 32'hFFFFFF85, lat);
        chk("int_neg_lat", lat, 37);
        expStr("-123");
        chkBytes("int_neg");

        runSyscall(32'd1, 32'd0, lat);
        chk("int_zero_lat", lat, 34);
        expStr("0");
        chkBytes("int_zero");

        runSyscall(32'd1, 32'd1000, lat);
        chk("int_1000_lat", lat, 37);
        expStr("1000");
        chkBytes("int_1000");

        runSyscall(32'd1, 32'h80000000, lat);
        chk("int_min_lat", lat, 44);
        expStr("-2147483648");
        chkBytes("int_min");

        runSyscall(32'd4, 32'h100, lat);
        chk("str_lat", lat, 9);
        expStr("Hi");
        chkBytes("str_hi");
        chk("str_reads", rdQ.size(), 3);
        for (int i = 0; i < 3 && i < rdQ.size(); i++) chk("str_rd_addr", rdQ[i], 32'h100 + i);

        runSyscall(32'd4, 32'h200, lat);
        chk("strmax_lat", lat, 771);
        expQ.delete();
        for (int i = 0; i < 256; i++) expQ.push_back(8'h41 + 8'(i % 26));
        chkBytes("strmax");
        chk("strmax_reads", rdQ.size(), 257);

        // Console stalls the 'Z' byte for 5 cycles
        bus.tx_ready = 1'b0;
        fork
            runSyscall(32'd11, 32'h5A, lat);
            begin
                @(posedge clock); #1;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clock);
                    if (k > 0) begin
                        chk("bp_tx_valid", bus.tx_valid, 1);
                        chk("bp_tx_data", bus.tx_data, 8'h5A);
                    end
                end
                @(posedge clock); #1;
                bus.tx_ready = 1'b1;
            end
        join
        chk("bp_lat", lat, 7);
        expStr("Z");
        chkBytes("bp_bytes");

        // Reset in the middle of CONV
        txQ.delete();
        @(posedge clock); #1;
        bus.syscall_valid = 1'b1;
        bus.syscall_funct = 32'd1;
        bus.syscall_param1 = 32'd12345;
        repeat (10) @(posedge clock);
        #1;
        bus.syscall_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        chk("mid_busy", bus.syscall_busy, 0);
        chk("mid_done", bus.syscall_done, 0);
        chk("mid_tx_valid", bus.tx_valid, 0);
        chk("mid_tx_data", bus.tx_data, 0);
        chk("mid_halted", bus.halted, 0);
        chk("mid_mem_addr", bus.mem_addr, 0);
        chk("mid_rd_en", bus.mem_rd_en, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        chk("mid_no_bytes", txQ.size(), 0);
        runSyscall(32'd11, 32'h37, lat);
        chk("mid_char_lat", lat, 2);
        expStr("7");
        chkBytes("mid_char");

        // exit2, then a later print_char must be ignored
        doneCnt = 0;
        @(posedge clock); #1;
        bus.syscall_valid = 1'b1;
        bus.syscall_funct = 32'd17;
        bus.syscall_param1 = 32'h2A;
        @(negedge clock);
        chk("exit_busy_acc", bus.syscall_busy, 1);
        chk("exit_halted_acc", bus.halted, 0);
        @(negedge clock);
        chk("exit_halted", bus.halted, 1);
        chk("exit_code", bus.exit_code, 8'h2A);
        chk("exit_busy", bus.syscall_busy, 1);
        @(posedge clock); #1;
        bus.syscall_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        txQ.delete();
        bus.syscall_valid = 1'b1;
        bus.syscall_funct = 32'd11;
        bus.syscall_param1 = 32'h43;
        repeat (10) @(negedge clock);
        chk("halt_busy", bus.syscall_busy, 1);
        chk("halt_sticky", bus.halted, 1);
        chk("halt_no_done", doneCnt, 0);
        chk("halt_no_bytes", txQ.size(), 0);
        bus.syscall_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/syscall_responder.md
# syscall_responder

Services the `syscall` requests issued by the pipelined MIPS core's decode stage. It holds the pipeline through a busy/done handshake while it runs the requested service. Services are byte-stream console output (character, signed decimal integer, NUL-terminated string read from data memory) and program exit. It sits beside the core: it takes the decode-stage syscall signals and feeds its busy output to the hazard unit as a stall source.

## Interface
Parameters:
- MAX_STR, default 256: maximum bytes emitted per print_string; emission stops after this count even with no NUL.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- syscall_valid  in  1  decode stage holds a syscall (syscallD).
- syscall_funct  in  32  service number ($v0).
- syscall_param1  in  32  argument ($a0).
- syscall_busy  out  1  stall request to the hazard unit; combinational.
- syscall_done  out  1  one-cycle pulse; the syscall has completed.
- mem_rd_en  out  1  byte-read strobe to data memory.
- mem_addr  out  32  byte address for the read.
- mem_rdata  in  8  read byte; valid exactly one cycle after mem_rd_en.
- tx_valid  out  1  console byte available.
- tx_data  out  8  console byte.
- tx_ready  in  1  console accepts the byte.
- halted  out  1  program has exited; sticky.
- exit_code  out  8  exit status.

## Operation
- Services by syscall_funct:
  - 1 = print_int (signed decimal of param1).
  - 4 = print_string (bytes starting at address param1).
  - 10 = exit (code 0).
  - 11 = print_char (param1[7:0]).
  - 17 = exit2 (code param1[7:0]).
  - Any other value is a no-op that still completes with done.
- States: IDLE, CHAR, CONV, SIGN, DIGIT, STR_RD, STR_WAIT, STR_EMIT, DONE, HALT.
- Acceptance:
  - A request is accepted in IDLE when syscall_valid=1; funct and param1 are captured that cycle.
  - syscall_busy = (IDLE & syscall_valid) | (state not in {IDLE, DONE}).
- CHAR: tx_valid=1 with tx_data=param1[7:0] until tx_ready; then go to DONE.
- print_int:
  - CONV runs a 32-iteration double-dabble of |param1| into 10 BCD digits, one iteration per cycle. |−2147483648| is treated as unsigned 2147483648.
  - If param1 is negative, SIGN emits '-' (0x2D).
  - DIGIT emits ASCII digits (0x30+d), most significant first, with leading zeros suppressed. Value 0 emits a single '0'.
- print_string:
  - STR_RD pulses mem_rd_en with mem_addr = current pointer.
  - STR_WAIT latches mem_rdata. If the byte is 0x00, or MAX_STR bytes have already been emitted, go to DONE.
  - Otherwise STR_EMIT sends the byte, increments the pointer (mod 2^32), and returns to STR_RD.
- Exit (10/17): go straight to HALT. halted=1, exit_code is set, syscall_busy=1 permanently, syscall_done is never pulsed, and no further requests are accepted. Only reset leaves HALT.
- DONE lasts one cycle:
  - syscall_done=1 and syscall_busy=0, so the stalled syscall advances.
  - syscall_valid is ignored this cycle, so the same syscall is never accepted twice.
  - Next state is IDLE.
- tx rules: tx_data is stable while tx_valid=1 and tx_ready=0. tx_valid never deasserts without a transfer.

## Timing
- Reset values (asynchronous, on reset_n low):
  - state is IDLE.
  - syscall_done, mem_rd_en, tx_valid, halted = 0.
  - tx_data, exit_code, mem_addr = 0.
  - syscall_busy = 0 unless syscall_valid is high.
- Reset asserted mid-service aborts immediately. Partial output is not resumed, and a tx byte in flight is dropped.
- Latency from accept to done pulse (tx_ready tied high):
  - print_char: 2 cycles (CHAR, DONE).
  - no-op: 1 cycle (DONE).
  - print_int: 32 cycles of CONV, +1 for sign, +1 per digit, +1 DONE.
  - print_string: 3 cycles per emitted byte, +2 for the terminating read, +1 DONE.
- Each tx_ready=0 cycle adds exactly one stall cycle.
- exit: halted rises on the cycle after acceptance.

## Test plan
- print_char, funct=11, param1=0x00000141, tx_ready=1: a single byte 0x41 is sent. busy is high for the accept cycle and CHAR, then done pulses 2 cycles after accept, with busy=0 in that cycle.
- print_int, param1=0xFFFFFF85 (−123): bytes 2D 31 32 33 are sent. Repeat with param1=0 (expect 30 only) and param1=0x80000000 (expect "-2147483648", 11 bytes).
- print_string, param1=0x100, memory at 0x100 holds "Hi\0": mem_rd_en pulses 3 times at addresses 0x100, 0x101, 0x102; bytes 48 69 are sent; done follows the NUL. A second run with a 300-byte string without NUL emits exactly 256 bytes.
- Backpressure: tx_ready=0 for 5 cycles during print_char 'Z': tx_valid stays high with 0x5A stable, and done is delayed by exactly 5 cycles.
- exit2 with param1=0x2A: halted=1 and exit_code=0x2A the next cycle. busy then stays 1 and done never pulses, even if funct=11 is presented afterwards.
- Reset mid-CONV: reset_n low for 1 cycle. All outputs return to reset values. A following print_char completes normally.
